// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin multi-channel arbiter onto a byte-serial RAM/IO bus
//
// Purpose: grants one of NUM_CH request channels at a time (round-robin), then
// streams the access byte by byte over the shared RAM/IO bus. Reads are assembled
// little-endian into rdata; writes are serialised from the latched write data.
// Writes into the IO window (addr[17:16] == 2'b11) wait while the UART buffer
// is full. Reads of channels selected by CLR_MASK are abandoned on clr_in.
//
// Ports:
//   clk_in, rst_in       clock, asynchronous active-low reset
//   rdy_in               global ready; low freezes the block and blocks writes
//   clr_in               misprediction flush (aborts masked reads)
//   io_buffer_full       UART tx buffer full
//   req_valid/wr/addr/len/wdata   per-channel request bundles, channel i in slice i
//   done                 one-hot, one-cycle completion pulse
//   rdata                last completed read, zero-extended
//   mem_din/mem_dout/mem_a/mem_wr   byte-serial memory bus
//   busy                 high whenever not idle
module mem_port_arbiter #(
   parameter int                NUM_CH    = 3,
   parameter int                MAX_BYTES = 4,
   parameter int                LEN_W     = 3,
   parameter logic [NUM_CH-1:0] CLR_MASK  = 3'b011
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          rdy_in,
   input  logic                          clr_in,
   input  logic                          io_buffer_full,
   input  logic [NUM_CH-1:0]             req_valid,
   input  logic [NUM_CH-1:0]             req_wr,
   input  logic [NUM_CH*32-1:0]          req_addr,
   input  logic [NUM_CH*LEN_W-1:0]       req_len,
   input  logic [NUM_CH*8*MAX_BYTES-1:0] req_wdata,
   output logic [NUM_CH-1:0]             done,
   output logic [8*MAX_BYTES-1:0]        rdata,
   input  logic [7:0]                    mem_din,
   output logic [7:0]                    mem_dout,
   output logic [31:0]                   mem_a,
   output logic                          mem_wr,
   output logic                          busy
);

   localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int               DW      = 8 * MAX_BYTES;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_IO_WAIT} state_e;

   state_e            state_q, state_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0]   grant_q, grant_d;
   logic [31:0]       addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW-1:0]     rbuf_q, rbuf_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic [NUM_CH-1:0] done_q, done_d;
   // ok_q: the address driven last cycle was issued while running, so mem_din
   // now carries byte cnt_q. Cleared by any frozen cycle, which makes the lost
   // byte's address be reissued on resume.
   logic              ok_q, ok_d;

   // ---------------- round-robin scan ----------------
   logic [NUM_CH-1:0] req_elig;
   logic              arb_found;
   logic [CH_W-1:0]   arb_idx;
   logic [CH_W:0]     scan_sum;
   logic [CH_W-1:0]   scan_c;

   always_comb begin
      // a channel completing this cycle still holds valid; keep it out
      req_elig  = req_valid & ~done_q;
      arb_found = 1'b0;
      arb_idx   = '0;
      scan_sum  = '0;
      scan_c    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         scan_sum = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
         if (scan_sum >= (CH_W+1)'(NUM_CH)) begin
            scan_sum = scan_sum - (CH_W+1)'(NUM_CH);
         end
         scan_c = scan_sum[CH_W-1:0];
         if (!arb_found && req_elig[scan_c]) begin
            arb_found = 1'b1;
            arb_idx   = scan_c;
         end
      end
   end

   // ---------------- datapath helpers ----------------
   logic [LEN_W-1:0] sel_len;
   logic [LEN_W-1:0] idx;
   logic [31:0]      cur_a;

   assign sel_len = req_len[int'(arb_idx)*LEN_W +: LEN_W];
   assign idx     = cnt_q + LEN_W'(ok_q);
   assign cur_a   = addr_q + 32'(idx);

   // ---------------- next state / outputs ----------------
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      addr_d   = addr_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      wdata_d  = wdata_q;
      rbuf_d   = rbuf_q;
      rdata_d  = rdata_q;
      ok_d     = 1'b0;
      // done holds through a freeze so the replay mask in IDLE survives it
      done_d   = rdy_in ? '0 : done_q;
      mem_a    = '0;
      mem_dout = '0;
      mem_wr   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rdy_in && arb_found) begin
               grant_d  = arb_idx;
               rr_ptr_d = (arb_idx == CH_W'(NUM_CH-1)) ? '0 : arb_idx + 1'b1;
               addr_d   = req_addr[int'(arb_idx)*32 +: 32];
               len_d    = (sel_len == '0 || sel_len > MAX_LEN) ? MAX_LEN : sel_len;
               wdata_d  = req_wdata[int'(arb_idx)*DW +: DW];
               cnt_d    = '0;
               rbuf_d   = '0;
               state_d  = req_wr[arb_idx] ? S_WRITE : S_READ;
            end
         end

         S_READ: begin
            if (idx < len_q) begin
               mem_a = cur_a;
            end
            if (rdy_in) begin
               if (clr_in && CLR_MASK[grant_q]) begin
                  state_d = S_IDLE;
               end else begin
                  if (ok_q) begin
                     rbuf_d[8*cnt_q +: 8] = mem_din;
                     cnt_d = cnt_q + LEN_W'(1);
                     if (cnt_d == len_q) begin
                        rdata_d          = rbuf_d;
                        done_d[grant_q]  = 1'b1;
                        state_d          = S_IDLE;
                     end
                  end
                  // after the last byte idx == len_q, so nothing more is issued
                  ok_d = (idx < len_q);
               end
            end
         end

         S_WRITE: begin
            if (cur_a[17:16] == 2'b11 && io_buffer_full) begin
               if (rdy_in) begin
                  state_d = S_IO_WAIT;
               end
            end else begin
               mem_a    = cur_a;
               mem_dout = wdata_q[8*cnt_q +: 8];
               mem_wr   = rdy_in;
               if (rdy_in) begin
                  if (cnt_q == len_q - LEN_W'(1)) begin
                     done_d[grant_q] = 1'b1;
                     state_d         = S_IDLE;
                  end else begin
                     cnt_d = cnt_q + LEN_W'(1);
                  end
               end
            end
         end

         S_IO_WAIT: begin
            if (rdy_in && !io_buffer_full) begin
               state_d = S_WRITE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         wdata_q  <= '0;
         rbuf_q   <= '0;
         rdata_q  <= '0;
         done_q   <= '0;
         ok_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         wdata_q  <= wdata_d;
         rbuf_q   <= rbuf_d;
         rdata_q  <= rdata_d;
         done_q   <= done_d;
         ok_q     <= ok_d;
      end
   end

   assign done  = done_q;
   assign rdata = rdata_q;
   assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clr_in, io_buffer_full;
   logic [2:0]  req_valid, req_wr;
   logic [95:0] req_addr;
   logic [8:0]  req_len;
   logic [95:0] req_wdata;
   logic [2:0]  done;
   logic [31:0] rdata;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr, busy;

   int n_pass  = 0;
   int n_total = 0;
   int done_cnt [3] = '{0, 0, 0};

   always #5 clk_in = ~clk_in;

   mem_port_arbiter dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
      .io_buffer_full(io_buffer_full),
      .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
      .req_len(req_len), .req_wdata(req_wdata),
      .done(done), .rdata(rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
      .mem_wr(mem_wr), .busy(busy)
   );

   // RAM model: one-cycle read latency, writes counted per address
   logic [7:0] ram [logic [31:0]];
   int         wr_cnt [logic [31:0]];

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      case (a)
         32'h100: return 8'h11;
         32'h101: return 8'h22;
         32'h102: return 8'h33;
         32'h103: return 8'h44;
         32'h180: return 8'hA1;
         32'h181: return 8'hB2;
         32'h182: return 8'hC3;
         32'h183: return 8'hD4;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : init_byte(a);
   endfunction

   function automatic int get_wr(input logic [31:0] a);
      return wr_cnt.exists(a) ? wr_cnt[a] : 0;
   endfunction

   always @(posedge clk_in) begin
      if (mem_wr) begin
         ram[mem_a]    = mem_dout;
         wr_cnt[mem_a] = get_wr(mem_a) + 1;
      end
      mem_din <= ram_rd(mem_a);
   end

   always @(negedge clk_in) begin
      for (int i = 0; i < 3; i++) begin
         if (done[i]) done_cnt[i]++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   typedef struct {
      int          ch;
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  len;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      int          exp_lat;   // grant edge to done edge, in cycles
   } vec_t;

   vec_t        vecs [8];
   logic [2:0]  dn;
   logic [31:0] rd;
   int          lat, base, frz_wr, stall_wr, n_order;
   int          order [6];

   task automatic set_req(input int ch, input logic wr, input logic [31:0] addr,
                          input logic [2:0] len, input logic [31:0] wd);
      req_wr[ch]               = wr;
      req_addr[32*ch +: 32]    = addr;
      req_len[3*ch +: 3]       = len;
      req_wdata[32*ch +: 32]   = wd;
      req_valid[ch]            = 1'b1;
   endtask

   task automatic run_txn(input vec_t v, output logic [2:0] d, output logic [31:0] r, output int l);
      set_req(v.ch, v.wr, v.addr, v.len, v.wdata);
      d = '0;
      r = '0;
      l = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk_in);
         if (done != 3'b000) begin
            d = done;
            r = rdata;
            l = c - 1;
            break;
         end
      end
      req_valid[v.ch] = 1'b0;
      @(negedge clk_in);
   endtask

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0; io_buffer_full = 1'b0;
      req_valid = '0; req_wr = '0; req_addr = '0; req_len = '0; req_wdata = '0;
      for (int k = 0; k < 6; k++) order[k] = -1;

      vecs[0] = '{1, 1'b0, 32'h0000_0100, 3'd4, 32'h0,         32'h4433_2211, 5};
      vecs[1] = '{2, 1'b0, 32'h0000_0101, 3'd2, 32'h0,         32'h0000_3322, 3};
      vecs[2] = '{0, 1'b0, 32'h0000_0180, 3'd0, 32'h0,         32'hD4C3_B2A1, 5};
      vecs[3] = '{1, 1'b0, 32'h0000_0182, 3'd7, 32'h0,         32'h0000_D4C3, 5};
      vecs[4] = '{0, 1'b1, 32'hFFFF_FFFE, 3'd3, 32'h00CC_BBAA, 32'h0,         3};
      vecs[5] = '{2, 1'b0, 32'hFFFF_FFFE, 3'd3, 32'h0,         32'h00CC_BBAA, 4};
      vecs[6] = '{1, 1'b1, 32'h0000_0300, 3'd1, 32'h0000_005A, 32'h0,         1};
      vecs[7] = '{0, 1'b0, 32'h0000_0300, 3'd1, 32'h0,         32'h0000_005A, 2};

      repeat (2) @(negedge clk_in);
      check("rst_done",  done,   3'b000);
      check("rst_rdata", rdata,  32'h0);
      check("rst_busy",  busy,   1'b0);
      check("rst_mem_wr", mem_wr, 1'b0);
      check("rst_mem_a", mem_a,  32'h0);
      rst_in = 1'b1;
      @(negedge clk_in);

      // single-channel vectors
      for (int i = 0; i < 8; i++) begin
         run_txn(vecs[i], dn, rd, lat);
         check($sformatf("vec%0d_done", i), dn, 3'b001 << vecs[i].ch);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      end

      // speculative abort on masked channel 0
      base = done_cnt[0];
      set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
      repeat (4) @(negedge clk_in);
      clr_in = 1'b1;
      req_valid[0] = 1'b0;
      @(negedge clk_in);
      clr_in = 1'b0;
      check("abort_idle", busy, 1'b0);
      repeat (4) @(negedge clk_in);
      check("abort_no_done", done_cnt[0] - base, 0);
      check("abort_rdata", rdata, vecs[7].exp_rd);

      // same flush against unmasked channel 2 completes
      set_req(2, 1'b0, 32'h100, 3'd4, 32'h0);
      repeat (4) @(negedge clk_in);
      clr_in = 1'b1;
      @(negedge clk_in);
      clr_in = 1'b0;
      dn = '0;
      for (int c = 0; c < 20; c++) begin
         if (done != 3'b000) begin dn = done; rd = rdata; break; end
         @(negedge clk_in);
      end
      req_valid[2] = 1'b0;
      check("unmasked_done", dn, 3'b100);
      check("unmasked_rdata", rd, 32'h4433_2211);
      repeat (2) @(negedge clk_in);

      // IO back-pressure
      base = done_cnt[1];
      io_buffer_full = 1'b1;
      set_req(1, 1'b1, 32'h0003_0000, 3'd1, 32'h41);
      stall_wr = 0;
      repeat (6) begin
         @(negedge clk_in);
         if (mem_wr) stall_wr++;
      end
      check("io_stall_no_wr", stall_wr, 0);
      check("io_wait_busy", busy, 1'b1);
      io_buffer_full = 1'b0;
      @(negedge clk_in);
      check("io_wr", mem_wr, 1'b1);
      check("io_addr", mem_a, 32'h0003_0000);
      check("io_dout", mem_dout, 8'h41);
      @(negedge clk_in);
      check("io_done", done, 3'b010);
      req_valid[1] = 1'b0;
      repeat (3) @(negedge clk_in);
      check("io_done_once", done_cnt[1] - base, 1);
      check("io_wr_once", get_wr(32'h0003_0000), 1);

      // freeze during byte 1 of a 2-byte write
      base = done_cnt[0];
      set_req(0, 1'b1, 32'h200, 3'd2, 32'hBEEF);
      @(negedge clk_in);
      check("frz_b0", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h200, 8'hEF});
      @(negedge clk_in);
      rdy_in = 1'b0;
      frz_wr = 0;
      repeat (3) begin
         #1;
         if (mem_wr) frz_wr++;
         @(negedge clk_in);
      end
      rdy_in = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_in);
         if (done != 3'b000) break;
      end
      req_valid[0] = 1'b0;
      repeat (3) @(negedge clk_in);
      check("frz_no_wr", frz_wr, 0);
      check("frz_ram200", ram_rd(32'h200), 8'hEF);
      check("frz_ram201", ram_rd(32'h201), 8'hBE);
      check("frz_done_once", done_cnt[0] - base, 1);
      check("frz_wr201_once", get_wr(32'h201), 1);

      // asynchronous reset mid-read
      set_req(1, 1'b0, 32'h100, 3'd4, 32'h0);
      repeat (2) @(negedge clk_in);
      #2 rst_in = 1'b0;
      #1;
      check("arst_busy",  busy,   1'b0);
      check("arst_mem_a", mem_a,  32'h0);
      check("arst_mem_wr", mem_wr, 1'b0);
      check("arst_done",  done,   3'b000);
      check("arst_rdata", rdata,  32'h0);
      req_valid = '0;
      @(negedge clk_in);
      rst_in = 1'b1;

      // round-robin with all channels continuously valid
      for (int ch = 0; ch < 3; ch++) set_req(ch, 1'b0, 32'h100 + 32'(ch), 3'd1, 32'h0);
      n_order = 0;
      for (int c = 0; c < 60 && n_order < 6; c++) begin
         @(negedge clk_in);
         if (done != 3'b000) begin
            order[n_order] = (done == 3'b001) ? 0 : (done == 3'b010) ? 1 :
                             (done == 3'b100) ? 2 : -1;
            n_order++;
         end
      end
      req_valid = '0;
      for (int k = 0; k < 6; k++) check($sformatf("rr_grant%0d", k), order[k], k % 3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised successor to the CPU's two-client memory controller.
- Arbitrates NUM_CH request channels round-robin onto the single byte-serial RAM/IO bus. Channel examples: instruction fetch, load/store buffer, prefetcher.
- Supports variable-length accesses of up to MAX_BYTES bytes, selective speculative-read abort on clr_in, and IO back-pressure.
- Sits between the front-end/LSB clients and the cpu top-level mem_* pins.

Parameters:
- NUM_CH, 3, number of request channels; channel 0 wins ties at reset.
- MAX_BYTES, 4, maximum bytes per access; data buses are 8*MAX_BYTES bits.
- LEN_W, 3, width of each length field; must satisfy 2^LEN_W > MAX_BYTES.
- CLR_MASK, 3'b011, bit i set: channel i's reads are aborted by clr_in.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global ready; low freezes the block
- clr_in  input  1  misprediction flush
- io_buffer_full  input  1  UART tx buffer full
- req_valid  input  NUM_CH  per-channel request; held until that channel's done
- req_wr  input  NUM_CH  1 = write
- req_addr  input  NUM_CH*32  channel i occupies bits [32i+31:32i]
- req_len  input  NUM_CH*LEN_W  byte count, 1..MAX_BYTES
- req_wdata  input  NUM_CH*8*MAX_BYTES  little-endian write data
- done  output  NUM_CH  one-cycle completion pulse, one-hot
- rdata  output  8*MAX_BYTES  read result, zero-extended; valid while done is high
- mem_din  input  8  RAM read byte, returned the cycle after its address
- mem_dout  output  8  RAM write byte
- mem_a  output  32  RAM address
- mem_wr  output  1  1 = write
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_in=0, async): state=IDLE; rr_ptr=0; done=0; rdata=0; mem_a=0; mem_dout=0; mem_wr=0; byte counter=0.
- States: IDLE, READ, WRITE, IO_WAIT.
- IDLE
  - Grant the first valid channel scanning upward from rr_ptr, wrapping modulo NUM_CH.
  - Latch that channel's addr, len, wr and wdata; set rr_ptr = grant+1 with wrap.
  - Go to READ or WRITE. Grant decision costs one cycle.
  - mem_wr=0 and mem_a=0 while in IDLE.
  - A channel whose done is high this cycle is masked from arbitration; this prevents replay of a request whose valid has not yet dropped.
- READ, length L
  - Cycle k (k=0..L-1) drives mem_a=addr+k, mem_wr=0.
  - The byte sampled on mem_din in cycle k+1 goes to rdata[8k+7:8k]; upper bytes are 0.
  - After byte L-1 is captured: done[grant]=1 for one cycle, state→IDLE.
  - Latency: grant edge to done pulse = L+1 cycles.
- WRITE, length L
  - Cycle k drives mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1.
  - After byte L-1: done[grant]=1 next cycle, state→IDLE. Total L+1 cycles.
- IO_WAIT
  - Before any write byte whose address has bits [17:16]=2'b11: if io_buffer_full=1, enter IO_WAIT with mem_wr=0, mem_a=0.
  - Stay until io_buffer_full=0, then issue that byte.
  - IO reads need no wait.
- rdy_in=0
  - All registers hold; mem_wr forced 0.
  - A read byte whose address was driven in a cycle with rdy_in=0 is not captured; on resume that address is reissued.
- clr_in=1
  - If state=READ and CLR_MASK[grant]=1: abort to IDLE next cycle, no done, rdata unchanged.
  - WRITE, IO_WAIT, and reads of unmasked channels complete normally.
  - clr_in in IDLE has no effect; masked requesters drop their own req_valid.
- req_len=0 or req_len>MAX_BYTES: treated as MAX_BYTES.
- Address arithmetic is 32-bit modulo; no alignment check.
- rst_in asserted mid-operation: immediate return to reset values; a partial write is not completed.

Test Plan:
- Read arbitration: ch1 reads 4 bytes at 0x100 (RAM 0x100..0x103 = 11,22,33,44) -> mem_a sweeps 0x100..0x103 with mem_wr=0; done[1] pulses 5 cycles after grant; rdata=0x44332211.
- Round-robin fairness: ch0, ch1 and ch2 all valid continuously, 1-byte reads -> grant order 0,1,2,0,1,2; no channel granted twice consecutively while others wait.
- IO back-pressure: ch1 writes 1 byte 0x41 to 0x30000 with io_buffer_full=1 for 6 cycles -> mem_wr stays 0 through the 6-cycle stall; the single write of 0x41 to 0x30000 occurs on the cycle after io_buffer_full falls; done[1] pulses once.
- Speculative abort: ch0 (masked) 4-byte read, clr_in pulsed after the 2nd byte -> no done[0]; next cycle IDLE. Repeat with ch2 (unmasked) -> done[2] with correct data.
- Freeze: rdy_in low for 3 cycles during byte 1 of a 2-byte write 0xBEEF to 0x200 -> mem_wr=0 during freeze; RAM[0x200]=0xEF, RAM[0x201]=0xBE; exactly one done.
- Async reset: rst_in low mid-READ -> all outputs 0 without a clock edge; after release, first grant goes to channel 0.
